// File: rtl/seq_unrotator_pkg.sv
// Shared state encoding and direction constants for seq_unrotator.
package seq_unrotator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } unrot_state_e;

    // Direction the upstream barrel shifter originally rotated the data.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/seq_unrotator_rot_step.sv
// Combinational single step wrap-around rotate by 1 or 2 bits in either direction.
module rot_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             left_i,
    input  logic             two_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] rol1, rol2, ror1, ror2;

    always_comb begin
        rol1 = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        rol2 = {data_i[WIDTH-3:0], data_i[WIDTH-1:WIDTH-2]};
        ror1 = {data_i[0], data_i[WIDTH-1:1]};
        ror2 = {data_i[1:0], data_i[WIDTH-1:2]};
        if (left_i) begin
            data_o = two_i ? rol2 : rol1;
        end else begin
            data_o = two_i ? ror2 : ror1;
        end
    end

endmodule

// File: rtl/seq_unrotator.sv
// Multi-cycle inverse rotator with valid/ready on both sides.
// Optional macro UNROT_STEP2_EN: rotate 2 bits per cycle while at least 2 remain.
module seq_unrotator
    import seq_unrotator_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam bit WIDTH_POW2 = ((WIDTH & (WIDTH - 1)) == 0);

    unrot_state_e     state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic             dir_q, dir_d;

    logic [SW-1:0]    amt_mod;
    logic             step2;
    logic [SW-1:0]    step_amt;
    logic [WIDTH-1:0] rot_data;

    // Amount field can exceed WIDTH-1 only when WIDTH is not a power of two.
    assign amt_mod = WIDTH_POW2 ? in_amt : SW'(in_amt % WIDTH);

`ifdef UNROT_STEP2_EN
    assign step2 = (rem_q >= SW'(2));
`else
    assign step2 = 1'b0;
`endif

    assign step_amt = step2 ? SW'(2) : SW'(1);

    // Undo the original rotation: a left rotate is reversed by rotating right.
    rot_step #(
        .WIDTH (WIDTH)
    ) u_rot_step (
        .data_i (data_q),
        .left_i (dir_q == DIR_RIGHT),
        .two_i  (step2),
        .data_o (rot_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            dir_q   <= DIR_LEFT;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = amt_mod;
                    dir_d   = in_dir;
                    state_d = (amt_mod == '0) ? ST_DONE : ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                data_d = rot_data;
                rem_d  = rem_q - step_amt;
                if (rem_q <= step_amt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_data = data_q;

endmodule
